// File: rtl/pc_pass_monitor.sv
// Watches the fetch PC of a core under test and reports how its program ended:
// pass signature, fail signature, PC hang, or cycle-budget timeout.
module pc_pass_monitor #(
    parameter int XLEN        = 32,
    parameter int MAX_CYCLES  = 2000,
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pc_valid,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  pass_addr,
    input  logic [XLEN-1:0]  pass_prev_addr,
    input  logic [XLEN-1:0]  fail_addr,
    input  logic             prev_check_en,
    input  logic             fail_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             hang,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    // state    | meaning
    // S_IDLE   | not armed since reset
    // S_RUN    | armed, evaluating one cycle per clock
    // S_PASS   | pass signature seen (terminal)
    // S_FAIL   | fail address fetched (terminal)
    // S_HANG   | PC stuck for STALL_LIMIT repeats (terminal)
    // S_TIMEOUT| MAX_CYCLES elapsed without a verdict (terminal)
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_HANG,
        S_TIMEOUT
    } state_t;

    localparam int SAME_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [SAME_W-1:0] SAME_MAX  = '1;
    localparam logic [SAME_W-1:0] STALL_LIM = SAME_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic              arm;
    logic [XLEN-1:0]   prev_pc;
    logic              prev_pc_valid;
    logic [SAME_W-1:0] same_cnt;
    logic [SAME_W-1:0] same_inc;
    logic [CNT_W-1:0]  cycle_k;
    logic              pc_same;
    logic              pass_hit;
    logic              fail_hit;
    logic              hang_hit;
    logic              timeout_hit;

    // Hit detection for evaluation cycle k = cycle_count + 1
    always_comb begin
        cycle_k     = cycle_count + 1'b1;
        pc_same     = pc_valid && prev_pc_valid && (pc == prev_pc);
        same_inc    = (same_cnt == SAME_MAX) ? same_cnt : same_cnt + 1'b1;
        pass_hit    = pc_valid && (pc == pass_addr) &&
                      (!prev_check_en || (prev_pc_valid && (prev_pc == pass_prev_addr)));
        fail_hit    = fail_en && pc_valid && (pc == fail_addr);
        hang_hit    = (STALL_LIMIT != 0) && pc_same && (same_inc == STALL_LIM);
        timeout_hit = (cycle_k == MAX_CNT);
    end

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        case (state)
            S_RUN: begin
                if (pass_hit) begin
                    state_nxt = S_PASS;
                end else if (fail_hit) begin
                    state_nxt = S_FAIL;
                end else if (hang_hit) begin
                    state_nxt = S_HANG;
                end else if (timeout_hit) begin
                    state_nxt = S_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_nxt = S_RUN;
                    arm       = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cycle_count   <= '0;
            prev_pc_valid <= 1'b0;
            same_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (arm) begin
                cycle_count   <= '0;
                prev_pc_valid <= 1'b0;
                same_cnt      <= '0;
            end else if (state == S_RUN) begin
                // Count ends at k even on the terminating edge, so it freezes at k
                cycle_count <= cycle_k;
                if (pc_valid) begin
                    prev_pc_valid <= 1'b1;
                    same_cnt      <= pc_same ? same_inc : '0;
                end
            end
        end
    end

    // prev_pc needs no reset: prev_pc_valid masks every use of it
    always_ff @(posedge clk) begin
        if (arm) begin
            prev_pc <= '0;
        end else if ((state == S_RUN) && pc_valid) begin
            prev_pc <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            hang    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            busy    <= (state_nxt == S_RUN);
            done    <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) ||
                       (state_nxt == S_HANG) || (state_nxt == S_TIMEOUT);
            pass    <= (state_nxt == S_PASS);
            fail    <= (state_nxt == S_FAIL);
            hang    <= (state_nxt == S_HANG);
            timeout <= (state_nxt == S_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_pc_pass_monitor.sv
// Bench for pc_pass_monitor: directed signature scenarios plus randomized traffic,
// checked every cycle against a history-based model of the monitor.
module tb_pc_pass_monitor;

    localparam int XLEN  = 32;
    localparam int MAXC  = 2000;
    localparam int STALL = 64;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             pc_valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pass_addr;
    logic [XLEN-1:0]  pass_prev_addr;
    logic [XLEN-1:0]  fail_addr;
    logic             prev_check_en;
    logic             fail_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic             hang;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    always #5 clk = ~clk;

    pc_pass_monitor #(
        .XLEN(XLEN), .MAX_CYCLES(MAXC), .STALL_LIMIT(STALL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc_valid(pc_valid), .pc(pc),
        .pass_addr(pass_addr), .pass_prev_addr(pass_prev_addr), .fail_addr(fail_addr),
        .prev_check_en(prev_check_en), .fail_en(fail_en),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .hang(hang),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    // Model: 0 idle, 1 run, 2 pass, 3 fail, 4 hang, 5 timeout
    int              m_state = 0;
    int              m_count = 0;
    logic [XLEN-1:0] hist[$];
    int              m_k;
    int              m_run;
    bit              m_ph, m_fh, m_hh, m_th;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0;
            m_count = 0;
            hist.delete();
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1;
                m_count = 0;
                hist.delete();
            end
        end else begin
            m_k  = m_count + 1;
            m_ph = pc_valid && (pc == pass_addr) &&
                   (!prev_check_en || (hist.size() > 0 && hist[$] == pass_prev_addr));
            m_fh = fail_en && pc_valid && (pc == fail_addr);
            m_hh = 1'b0;
            if (pc_valid) begin
                // length of the trailing run of samples equal to this pc
                m_run = 0;
                for (int i = hist.size() - 1; i >= 0; i--) begin
                    if (hist[i] != pc) break;
                    m_run++;
                end
                m_hh = (STALL != 0) && (m_run == STALL);
                hist.push_back(pc);
            end
            m_th    = (m_k == MAXC);
            m_count = m_k;
            if (m_ph)      m_state = 2;
            else if (m_fh) m_state = 3;
            else if (m_hh) m_state = 4;
            else if (m_th) m_state = 5;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    endtask

    task automatic cmp_model();
        logic [CNT_W+5:0] act;
        logic [CNT_W+5:0] exp;
        act = {busy, done, pass, fail, hang, timeout, cycle_count};
        exp = {m_state == 1, m_state >= 2, m_state == 2, m_state == 3,
               m_state == 4, m_state == 5, CNT_W'(m_count)};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL model_cmp got=%h expected=%h t=%0t", act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        if (checking) cmp_model();
    endtask

    task automatic cyc(input bit v, input logic [XLEN-1:0] a);
        pc_valid = v;
        pc       = a;
        tick();
    endtask

    task automatic arm();
        start    = 1'b1;
        pc_valid = 1'b0;
        tick();
        start    = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] pick();
        return XLEN'(32'h10 + 4 * $urandom_range(0, 3));
    endfunction

    bit sticky;

    initial begin
        rst_n = 1'b0; start = 1'b0; pc_valid = 1'b0; pc = '0;
        pass_addr = 32'h6B4; pass_prev_addr = 32'h69C; fail_addr = 32'hFFF0;
        prev_check_en = 1'b1; fail_en = 1'b0;
        tick();
        checking = 1'b1;
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;

        // Pass via 0x69C -> 0x6B4 on cycle 40
        arm();
        for (int k = 1; k <= 37; k++) cyc(1'b1, 32'h1000 + 4 * k);
        cyc(1'b1, 32'h698);
        cyc(1'b1, 32'h69C);
        chk("t1_not_yet", pass, 0);
        cyc(1'b1, 32'h6B4);
        chk("t1_pass", pass, 1);
        chk("t1_done", done, 1);
        chk("t1_count", cycle_count, 40);

        // Re-arm from PASS; wrong predecessor, then stuck PC -> hang
        arm();
        chk("t2_rearm_pass", pass, 0);
        chk("t2_rearm_count", cycle_count, 0);
        cyc(1'b1, 32'h6B0);
        cyc(1'b1, 32'h6B4);
        chk("t2_no_pass", pass, 0);
        for (int i = 0; i < 63; i++) cyc(1'b1, 32'h6B4);
        chk("t2_not_hung", busy, 1);
        cyc(1'b1, 32'h6B4);
        chk("t2_hang", hang, 1);
        chk("t2_pass0", pass, 0);
        chk("t2_count", cycle_count, 66);

        // Arrival-only pass on the first cycle
        prev_check_en = 1'b0; pass_addr = 32'h41C;
        arm();
        cyc(1'b1, 32'h41C);
        chk("t3_pass", pass, 1);
        chk("t3_count", cycle_count, 1);

        // Timeout with toggling pc_valid, start pulse mid-run ignored
        prev_check_en = 1'b1; pass_addr = 32'h6B4;
        arm();
        for (int k = 1; k <= MAXC; k++) begin
            start = (k == 100);
            cyc(k[0], 32'h20000 + 4 * k);
            start = 1'b0;
            if (k == 100) chk("t4_start_ignored", cycle_count, 100);
            if (k == MAXC - 1) chk("t4_busy", busy, 1);
        end
        chk("t4_timeout", timeout, 1);
        chk("t4_count", cycle_count, MAXC);
        cyc(1'b1, 32'h6B4);
        cyc(1'b1, 32'h6B4);
        chk("t4_hold", cycle_count, MAXC);

        // Pass beats fail on the same address; then fail alone
        prev_check_en = 1'b0; pass_addr = 32'h300; fail_addr = 32'h300; fail_en = 1'b1;
        arm();
        cyc(1'b1, 32'h300);
        chk("t5_pass_wins", pass, 1);
        chk("t5_fail0", fail, 0);
        fail_addr = 32'h304;
        arm();
        cyc(1'b0, 32'h304);
        cyc(1'b1, 32'h304);
        chk("t5_fail", fail, 1);
        chk("t5_fail_count", cycle_count, 2);
        fail_en = 1'b0; prev_check_en = 1'b1; pass_addr = 32'h6B4;

        // Reset mid-run at cycle 500, then re-arm
        arm();
        for (int k = 1; k <= 499; k++) cyc(1'b1, 32'h50000 + 4 * k);
        rst_n = 1'b0;
        cyc(1'b1, 32'h6B4);
        rst_n = 1'b1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_count", cycle_count, 0);
        arm();
        chk("t6_rearm", busy, 1);
        cyc(1'b1, 32'h10); cyc(1'b0, 32'h10); cyc(1'b1, 32'h14);
        chk("t6_count3", cycle_count, 3);

        // Randomized traffic over a small address set
        sticky = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pass_addr      = pick();
                pass_prev_addr = pick();
                fail_addr      = pick();
                prev_check_en  = $urandom_range(0, 1) != 0;
                fail_en        = $urandom_range(0, 1) != 0;
            end
            if ($urandom_range(0, 99) == 0) sticky = !sticky;
            start    = ($urandom_range(0, 49) == 0);
            rst_n    = ($urandom_range(0, 999) != 0);
            pc_valid = ($urandom_range(0, 3) != 0);
            if (!sticky) pc = pick();
            tick();
        end
        rst_n = 1'b1; start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
